// File: rtl/nand_bist_pkg.sv
// Shared types, constants and helpers for the NAND-bank BIST sequencer.
// Helpers take vectors up to MAX_W bits, so the bank is limited to 64 gates.
package nand_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_BASE = 4;

    // Base vectors as {a,b}: bit 1 goes to every A input, bit 0 to every B input.
    localparam logic [1:0] BASE_VEC [NUM_BASE] = '{2'b00, 2'b01, 2'b10, 2'b11};

    localparam int MAX_W = 64;

    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // Adds inc to acc and clamps the result at 2^w-1 (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] inc,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, acc} + {1'b0, inc};
        max_val = (33'd1 << w) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/nand_bist_ctrl_settle_timer.sv
// Settle timer: loaded whenever a new vector is driven, raises expire once the
// vector has been held for SETTLE+1 cycles so the sequencer can sample.
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    logic [CW-1:0] cnt;

    // Down-counter: reload to SETTLE with each new vector, then count to zero.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(SETTLE);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Expire in the cycle before the sampling edge; only meaningful mid-run.
    assign expire = run && (cnt == '0);

endmodule

// File: rtl/nand_bist_ctrl.sv
// BIST sequencer for a bank of 2-input NAND gates. Drives every {a,b} vector
// onto all gates, waits SETTLE+1 cycles, samples f_i and accumulates a sticky
// per-gate failure mask and a saturating mismatch count.
// Optional feature: define NAND_BIST_WALK_EN to append WIDTH walking vectors
// (a=b=1 on one gate at a time) that expose bridging between gates.
module nand_bist_ctrl
    import nand_bist_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic [WIDTH-1:0] f_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] fail_mask
);

    state_t           state, state_d;
    logic             load, expire, accept, sample, last_vec;
    logic [1:0]       base_idx, base_idx_d;
    logic [WIDTH-1:0] a_d, b_d;
    logic [WIDTH-1:0] expected, mismatch;
    logic [ERR_W-1:0] err_sum;

`ifdef NAND_BIST_WALK_EN
    localparam int WW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic          walk_phase, walk_phase_d;
    logic [WW-1:0] walk_idx, walk_idx_d;
`endif

    settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .run    (state == DRIVE),
        .expire (expire)
    );

    // Start is honoured only outside a run; a sample happens when the hold ends.
    assign accept = start && (state != DRIVE);
    assign sample = (state == DRIVE) && expire;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic and settle-timer reload.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    load    = 1'b1;
                end
            end
            DRIVE: begin
                if (expire) begin
                    load = 1'b1;
                    if (last_vec) state_d = DONE;
                end
            end
            DONE: begin
                load    = start;
                state_d = start ? DRIVE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next vector to drive after the current one is sampled, and last-vector flag.
    always_comb begin
        base_idx_d = base_idx;
        a_d        = '0;
        b_d        = '0;
        last_vec   = 1'b0;
`ifdef NAND_BIST_WALK_EN
        walk_phase_d = walk_phase;
        walk_idx_d   = walk_idx;
        if (walk_phase) begin
            last_vec   = (walk_idx == WW'(WIDTH - 1));
            walk_idx_d = walk_idx + WW'(1);
            a_d        = WIDTH'(1) << walk_idx_d;
            b_d        = WIDTH'(1) << walk_idx_d;
        end else if (base_idx == 2'(NUM_BASE - 1)) begin
            walk_phase_d = 1'b1;
            walk_idx_d   = '0;
            a_d          = WIDTH'(1);
            b_d          = WIDTH'(1);
        end else begin
            base_idx_d = base_idx + 2'd1;
            a_d        = {WIDTH{BASE_VEC[base_idx_d][1]}};
            b_d        = {WIDTH{BASE_VEC[base_idx_d][0]}};
        end
`else
        if (base_idx == 2'(NUM_BASE - 1)) begin
            last_vec = 1'b1;
        end else begin
            base_idx_d = base_idx + 2'd1;
            a_d        = {WIDTH{BASE_VEC[base_idx_d][1]}};
            b_d        = {WIDTH{BASE_VEC[base_idx_d][0]}};
        end
`endif
    end

    // Compare each gate against the ideal NAND; X or Z on f_i counts as a failure.
    always_comb begin
        expected = ~(a_o & b_o);
        mismatch = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mismatch[i] = (f_i[i] !== expected[i]);
        end
    end

    assign err_sum = ERR_W'(sat_add(32'(err_cnt), popcount(MAX_W'(mismatch)), ERR_W));

    // Datapath: vector drive, result accumulation and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_o       <= '0;
            b_o       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_mask <= '0;
            base_idx  <= '0;
`ifdef NAND_BIST_WALK_EN
            walk_phase <= 1'b0;
            walk_idx   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                err_cnt   <= '0;
                fail_mask <= '0;
                pass      <= 1'b0;
                busy      <= 1'b1;
                a_o       <= {WIDTH{BASE_VEC[0][1]}};
                b_o       <= {WIDTH{BASE_VEC[0][0]}};
                base_idx  <= '0;
`ifdef NAND_BIST_WALK_EN
                walk_phase <= 1'b0;
                walk_idx   <= '0;
`endif
            end else if (sample) begin
                fail_mask <= fail_mask | mismatch;
                err_cnt   <= err_sum;
                if (last_vec) begin
                    a_o  <= '0;
                    b_o  <= '0;
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_sum == '0);
                end else begin
                    a_o      <= a_d;
                    b_o      <= b_d;
                    base_idx <= base_idx_d;
`ifdef NAND_BIST_WALK_EN
                    walk_phase <= walk_phase_d;
                    walk_idx   <= walk_idx_d;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_nand_bist_ctrl.sv
// Self-checking bench for nand_bist_ctrl. Two instances share a behavioural
// NAND bank with injectable faults: A (SETTLE=2, ERR_W=3) and B (SETTLE=0,
// ERR_W=8). Expected run results are queued at launch; a monitor compares the
// drive timeline every cycle and pops results whenever done is presented.
module tb_nand_bist_ctrl;

    localparam int W   = 4;
    localparam int S_A = 2;
    localparam int E_A = 3;
    localparam int S_B = 0;
    localparam int E_B = 8;
`ifdef NAND_BIST_WALK_EN
    localparam int N_VEC = 4 + W;
`else
    localparam int N_VEC = 4;
`endif

    typedef struct {
        int           err;
        logic [W-1:0] mask;
        bit           pass;
        int           start_edge;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_a, start_b;
    logic [W-1:0] a_a, b_a, f_a, mask_a;
    logic [W-1:0] a_b, b_b, f_b, mask_b;
    logic         busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [E_A-1:0] err_a;
    logic [E_B-1:0] err_b;

    // Fault configuration of the bank: stuck-at-0, stuck-at-1, inverted, bridged pair.
    logic [W-1:0] flt_s0, flt_s1, flt_inv;
    int           flt_br;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   cur_a = -1;
    int   cur_b = -1;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural bank: ideal NAND, then faults; a bridge is a wired-AND of two outputs.
    function automatic logic [W-1:0] bank(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] s0, input logic [W-1:0] s1,
                                          input logic [W-1:0] inv, input int br);
        logic [W-1:0] g;
        logic         both;
        g = ~(a & b);
        g = (g & ~s0) | s1;
        g = g ^ inv;
        if (br >= 0) begin
            both      = g[br] & g[br+1];
            g[br]     = both;
            g[br+1]   = both;
        end
        return g;
    endfunction

    assign f_a = bank(a_a, b_a, flt_s0, flt_s1, flt_inv, flt_br);
    assign f_b = bank(a_b, b_b, flt_s0, flt_s1, flt_inv, flt_br);

    nand_bist_ctrl #(.WIDTH(W), .SETTLE(S_A), .ERR_W(E_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .a_o(a_a), .b_o(b_a), .f_i(f_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_mask(mask_a)
    );

    nand_bist_ctrl #(.WIDTH(W), .SETTLE(S_B), .ERR_W(E_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .a_o(a_b), .b_o(b_b), .f_i(f_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_mask(mask_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Vector k of the test sequence, straight from its definition.
    function automatic logic [W-1:0] vec_a(input int k);
        if (k < 4) return ((k & 2) != 0) ? {W{1'b1}} : {W{1'b0}};
        return W'(1) << (k - 4);
    endfunction

    function automatic logic [W-1:0] vec_b(input int k);
        if (k < 4) return ((k & 1) != 0) ? {W{1'b1}} : {W{1'b0}};
        return W'(1) << (k - 4);
    endfunction

    // Reference result of a whole run against the current fault configuration.
    function automatic exp_t model(input int erw);
        exp_t         x;
        int           mx;
        logic [W-1:0] a, b, mm;
        mx     = (1 << erw) - 1;
        x.err  = 0;
        x.mask = '0;
        for (int k = 0; k < N_VEC; k++) begin
            a      = vec_a(k);
            b      = vec_b(k);
            mm     = bank(a, b, flt_s0, flt_s1, flt_inv, flt_br) ^ ~(a & b);
            x.mask = x.mask | mm;
            x.err  = x.err + $countones(mm);
            if (x.err > mx) x.err = mx;
        end
        x.pass       = (x.err == 0);
        x.start_edge = 0;
        return x;
    endfunction

    // Per-cycle monitor for one instance: drive timeline, busy, done, results.
    task automatic mon_dut(input bit sel);
        logic [W-1:0] a, b, m, ea, eb;
        logic         bz, dn, ps, ebusy, edone;
        int unsigned  er;
        int           cur, s, e, span;
        exp_t         x;
        string        nm;
        if (sel) begin
            a = a_b; b = b_b; m = mask_b; bz = busy_b; dn = done_b; ps = pass_b;
            er = 32'(err_b); cur = cur_b; s = S_B; nm = "B";
        end else begin
            a = a_a; b = b_a; m = mask_a; bz = busy_a; dn = done_a; ps = pass_a;
            er = 32'(err_a); cur = cur_a; s = S_A; nm = "A";
        end
        span  = N_VEC * (s + 1);
        ea    = '0;
        eb    = '0;
        ebusy = 1'b0;
        edone = 1'b0;
        if (cur >= 0) begin
            e = cyc - cur;
            if (e < span) begin
                ea    = vec_a(e / (s + 1));
                eb    = vec_b(e / (s + 1));
                ebusy = 1'b1;
            end
            edone = (e == span);
        end
        check({nm, "_a_o"}, a, ea);
        check({nm, "_b_o"}, b, eb);
        check({nm, "_busy"}, bz, ebusy);
        check({nm, "_done"}, dn, edone);
        if (dn) begin
            if ((sel ? q_b.size() : q_a.size()) == 0) begin
                check({nm, "_done_unexpected"}, dn, 1'b0);
            end else begin
                x = sel ? q_b.pop_front() : q_a.pop_front();
                check({nm, "_err_cnt"}, er, x.err);
                check({nm, "_fail_mask"}, m, x.mask);
                check({nm, "_pass"}, ps, x.pass);
                check({nm, "_done_edge"}, cyc - x.start_edge, span);
                if (sel) cur_b = -1; else cur_a = -1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_dut(1'b0);
            mon_dut(1'b1);
        end
    end

    // Call just after a falling edge; start is sampled by the next rising edge.
    task automatic launch(input bit sel);
        exp_t x;
        x            = model(sel ? E_B : E_A);
        x.start_edge = cyc + 1;
        if (sel) begin
            q_b.push_back(x);
            cur_b   = cyc + 1;
            start_b = 1'b1;
        end else begin
            q_a.push_back(x);
            cur_a   = cyc + 1;
            start_a = 1'b1;
        end
        @(negedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Waits (bounded) for done, returning just after the falling edge of the done cycle.
    task automatic wait_done(input bit sel);
        int budget;
        bit got;
        budget = N_VEC * ((sel ? S_B : S_A) + 1) + 4;
        got    = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sel ? done_b : done_a) begin
                got = 1'b1;
                break;
            end
        end
        check(sel ? "B_done_seen" : "A_done_seen", got, 1'b1);
        if (!got) begin
            if (sel) begin q_b.delete(); cur_b = -1; end
            else begin q_a.delete(); cur_a = -1; end
        end
        #1;
    endtask

    task automatic clear_faults();
        flt_s0  = '0;
        flt_s1  = '0;
        flt_inv = '0;
        flt_br  = -1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_A_outs"}, {a_a, b_a, busy_a, done_a, pass_a, err_a, mask_a}, '0);
        check({tag, "_B_outs"}, {a_b, b_b, busy_b, done_b, pass_b, err_b, mask_b}, '0);
    endtask

    task automatic run_one(input bit sel);
        launch(sel);
        wait_done(sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        clear_faults();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        #1 rst_n = 1'b1;
        @(negedge clk); #1;

        // Good bank on both instances.
        run_one(1'b0);
        run_one(1'b1);

        // Gate 2 stuck at 1: only vector 11 fails.
        flt_s1 = 4'b0100;
        run_one(1'b0);
        clear_faults();

        // Gate 0 always wrong: four failures.
        flt_inv = 4'b0001;
        run_one(1'b0);
        clear_faults();

        // All gates stuck at 0: 12 failures saturate on A, not on B.
        flt_s0 = '1;
        run_one(1'b0);
        run_one(1'b1);
        clear_faults();

        // Start re-pulsed mid-run is ignored.
        launch(1'b0);
        repeat (3) @(negedge clk);
        #1 start_a = 1'b1;
        @(negedge clk); #1 start_a = 1'b0;
        wait_done(1'b0);

        // Reset taken at edge 5 of a run: aborts with no done.
        flt_s1 = 4'b0010;
        launch(1'b0);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        cur_a = -1;
        q_a.delete();
        #1 check_all_zero("abort");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (N_VEC * (S_A + 1)) @(negedge clk);
        #1;

        // SETTLE=0 run followed by a start in its DONE cycle.
        flt_s1 = 4'b0100;
        launch(1'b1);
        wait_done(1'b1);
        launch(1'b1);
        check("B_restart_err", err_b, '0);
        check("B_restart_mask", mask_b, '0);
        check("B_restart_pass", pass_b, 1'b0);
        wait_done(1'b1);
        clear_faults();

        // Gates 1 and 2 bridged: invisible to base vectors, caught by walking ones.
        flt_br = 1;
        run_one(1'b0);
        clear_faults();

        // Randomised fault configurations and instances.
        for (int it = 0; it < 16; it++) begin
            bit sel;
            int kind;
            sel  = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 4);
            clear_faults();
            case (kind)
                1: flt_s1  = W'(1) << $urandom_range(0, W - 1);
                2: flt_s0  = W'($urandom);
                3: flt_inv = W'($urandom);
                4: flt_br  = $urandom_range(0, W - 2);
                default: ;
            endcase
            launch(sel);
            if ($urandom_range(0, 1) == 1) begin
                int span;
                span = N_VEC * ((sel ? S_B : S_A) + 1);
                repeat ($urandom_range(1, span - 2) - 1) @(negedge clk);
                #1;
                if (sel) start_b = 1'b1; else start_a = 1'b1;
                @(negedge clk); #1;
                start_a = 1'b0;
                start_b = 1'b0;
            end
            wait_done(sel);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
        end

        repeat (3) @(negedge clk);
        check("A_queue_empty", q_a.size(), 0);
        check("B_queue_empty", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
